// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: imem request/response, execute redirect, decode handoff.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc4,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Registered ring-buffer FIFO of {pc, instr}; clear wins over push/pop.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  fetch_entry_t       push_data,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) rptr_d = rptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: owns the PC, issues credit-limited imem requests,
// buffers responses for decode and drains stale responses after a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    if_stage_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, push_data;
    logic             push, clear, pop, id_valid;
    logic             req_valid, req_fire, resp;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      redir_pc;

    assign id_valid    = (fifo_count != '0);
    assign pop         = id_valid & bus.id_ready;
    // Counting the entry decode pops this cycle keeps 1 instr/cycle at DEPTH=2.
    assign credit_used = (CNT_W+1)'(inflight_q) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
    assign req_valid   = (state_q == FETCH_RUN) && (credit_used < (CNT_W+1)'(DEPTH));
    assign req_fire    = req_valid & bus.imem_req_ready;
    assign resp        = bus.imem_resp_valid;
    assign redir_pc    = word_align(bus.redirect_pc);
    assign push_data   = '{pc: resp_pc_q, instr: bus.imem_resp_data};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp);
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        clear      = 1'b0;
        if (bus.redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old stream.
            clear      = 1'b1;
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            drop_cnt_d = inflight_d;
            state_d    = (inflight_d != '0) ? FETCH_FLUSH : FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_BOOT: state_d = FETCH_RUN;
                FETCH_RUN: if (resp) begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
                FETCH_FLUSH: begin
                    if (resp) drop_cnt_d = drop_cnt_q - 1'b1;
                    if (drop_cnt_d == '0) state_d = FETCH_RUN;
                end
                default: state_d = FETCH_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FETCH_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_data),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_instr       = id_valid ? fifo_head.instr : INSTR_NOP;
    assign bus.id_pc          = id_valid ? fifo_head.pc : resp_pc_q;
    assign bus.id_pc4         = bus.id_pc + 32'd4;
endmodule
